// File: rtl/count_checker.sv
// Consumer-side checker for the counting stream {v, v+1}, v += 2 per word.
// Drains the RX FIFO, locks onto the pattern and reports counts, lock state and a per-word error strobe.
module count_checker #(
    parameter int CNT_WIDTH     = 32,
    parameter int ERR_WIDTH     = 16,
    parameter int RESYNC_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [15:0]          in,
    input  logic                 empty,
    output logic                 rd_en,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [ERR_WIDTH-1:0] error_count
);

    localparam int MISS_W = $clog2(RESYNC_THRESH + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(RESYNC_THRESH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 r_dataValid;
    logic [15:0]          r_expected;
    logic [15:0]          w_expectedNext;
    logic [15:0]          w_expectedAdv;
    logic [MISS_W-1:0]    r_missRun;
    logic [MISS_W-1:0]    w_missRunNext;
    logic [MISS_W-1:0]    w_missRunInc;
    logic                 r_err;
    logic                 w_errNext;
    logic [CNT_WIDTH-1:0] r_wordCount;
    logic [CNT_WIDTH-1:0] w_wordCountNext;
    logic [ERR_WIDTH-1:0] r_errorCount;
    logic [ERR_WIDTH-1:0] w_errorCountNext;
    logic [7:0]           w_inHiPlus1;
    logic [7:0]           w_inHiPlus2;
    logic [7:0]           w_inHiPlus3;

    // Reading is gated by empty here, so the FIFO can never be over-read.
    assign rd_en = enable & ~empty;

    assign w_inHiPlus1   = in[15:8] + 8'd1;
    assign w_inHiPlus2   = in[15:8] + 8'd2;
    assign w_inHiPlus3   = in[15:8] + 8'd3;
    assign w_expectedAdv = {r_expected[15:8] + 8'd2, r_expected[7:0] + 8'd2};
    assign w_missRunInc  = r_missRun + MISS_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_dataValid  <= 1'b0;
            r_expected   <= 16'h0000;
            r_missRun    <= '0;
            r_err        <= 1'b0;
            r_wordCount  <= '0;
            r_errorCount <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_dataValid  <= rd_en;
            r_expected   <= w_expectedNext;
            r_missRun    <= w_missRunNext;
            r_err        <= w_errNext;
            r_wordCount  <= w_wordCountNext;
            r_errorCount <= w_errorCountNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_expectedNext   = r_expected;
        w_missRunNext    = r_missRun;
        w_errNext        = 1'b0;
        w_wordCountNext  = r_wordCount;
        w_errorCountNext = r_errorCount;
        if (r_dataValid) begin
            w_wordCountNext = r_wordCount + CNT_WIDTH'(1);
            case (r_state)
                HUNT: begin
                    if (in[7:0] == w_inHiPlus1) begin
                        w_expectedNext = {w_inHiPlus2, w_inHiPlus3};
                        w_missRunNext  = '0;
                        w_stateNext    = LOCKED;
                    end
                end
                LOCKED: begin
                    // Expected advances even on a miss so a single bad word does not shift alignment.
                    w_expectedNext = w_expectedAdv;
                    if (in == r_expected) begin
                        w_missRunNext = '0;
                    end else begin
                        w_errNext = 1'b1;
                        if (r_errorCount != '1) begin
                            w_errorCountNext = r_errorCount + ERR_WIDTH'(1);
                        end
                        if (w_missRunInc == MISS_LIMIT) begin
                            w_missRunNext = '0;
                            w_stateNext   = HUNT;
                        end else begin
                            w_missRunNext = w_missRunInc;
                        end
                    end
                end
                default: w_stateNext = HUNT;
            endcase
        end
    end

    assign locked      = (r_state == LOCKED);
    assign err         = r_err;
    assign word_count  = r_wordCount;
    assign error_count = r_errorCount;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: a FIFO model feeds words, expected err/locked per word are queued
// on acceptance and popped by a monitor when the checker samples that word.
module tb_count_checker;

    localparam int CNT_W = 32;
    localparam int ERR_W = 3;

    typedef struct {
        logic [15:0] word;
        logic        expErr;
        logic        expLocked;
    } entry_t;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             enable  = 1'b0;
    logic [15:0]      in      = 16'h0000;
    logic             empty   = 1'b1;
    logic             rd_en;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] word_count;
    logic [ERR_W-1:0] error_count;

    logic   enReq   = 1'b0;
    logic   gapMode = 1'b0;
    logic   accPrev = 1'b0;
    entry_t fifoQ[$];
    entry_t sbQ[$];
    int     checks   = 0;
    int     failures = 0;

    count_checker #(
        .CNT_WIDTH    (CNT_W),
        .ERR_WIDTH    (ERR_W),
        .RESYNC_THRESH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in         (in),
        .empty      (empty),
        .rd_en      (rd_en),
        .locked     (locked),
        .err        (err),
        .word_count (word_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word, input logic expErr, input logic expLocked);
        entry_t e;
        e.word      = word;
        e.expErr    = expErr;
        e.expLocked = expLocked;
        fifoQ.push_back(e);
    endtask

    task automatic pushCleanStream(input logic [7:0] startV, input int n);
        logic [7:0] v;
        v = startV;
        for (int i = 0; i < n; i++) begin
            applyStimulus({v, v + 8'd1}, 1'b0, 1'b1);
            v = v + 8'd2;
        end
    endtask

    task automatic waitDrain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(posedge clk);
            #3;
            if (fifoQ.size() == 0 && sbQ.size() == 0) done = 1'b1;
        end
        if (!done) checkOutput({name, "_drain_timeout"}, 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic doReset();
        enReq = 1'b0;
        waitDrain("pre_reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);
        checkOutput("rst_error_count", 32'(error_count), 32'd0);
        checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    endtask

    // FIFO model: an accepted read puts the word on `in` for the next cycle and queues its expectation.
    always @(posedge clk) begin
        logic   acc;
        logic   rs;
        entry_t e;
        acc = rd_en;
        rs  = rst_n;
        #1;
        if (acc) begin
            if (fifoQ.size() == 0) begin
                checkOutput("fifo_underflow", 32'd1, 32'd0);
            end else begin
                e  = fifoQ.pop_front();
                in = e.word;
                if (rs) sbQ.push_back(e);
            end
        end
        empty  = (fifoQ.size() == 0) || (gapMode && ($urandom_range(0, 2) == 0));
        enable = enReq && !(gapMode && ($urandom_range(0, 3) == 0));
    end

    // Monitor: a word accepted on the previous edge is sampled on this edge; reset discards it.
    always @(posedge clk) begin
        logic   a;
        entry_t e;
        a = accPrev;
        accPrev = rst_n && rd_en;
        if (a) begin
            if (!rst_n) begin
                if (sbQ.size() > 0) sbQ.delete(0);
            end else begin
                #1;
                if (sbQ.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput($sformatf("err_w%04h", e.word), 32'(err), 32'(e.expErr));
                    checkOutput($sformatf("locked_w%04h", e.word), 32'(locked), 32'(e.expLocked));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (gapMode) checkOutput("rd_en_while_empty", 32'(rd_en && empty), 32'd0);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic hit;
        doReset();

        // Clean 200-word stream crossing FEFF -> 0001.
        pushCleanStream(8'h00, 200);
        enReq = 1'b1;
        waitDrain("clean200");
        checkOutput("clean200_word_count", 32'(word_count), 32'd200);
        checkOutput("clean200_error_count", 32'(error_count), 32'd0);
        doReset();

        // Hunt skips 1234, locks on 0405; then a corrupted word; then four misses and relock.
        applyStimulus(16'h1234, 1'b0, 1'b0);
        applyStimulus(16'h0405, 1'b0, 1'b1);
        applyStimulus(16'h0607, 1'b0, 1'b1);
        enReq = 1'b1;
        waitDrain("hunt");
        checkOutput("hunt_word_count", 32'(word_count), 32'd3);
        checkOutput("hunt_error_count", 32'(error_count), 32'd0);

        applyStimulus(16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h0A0B, 1'b0, 1'b1);
        applyStimulus(16'h0C0D, 1'b0, 1'b1);
        waitDrain("single_bad");
        checkOutput("single_bad_error_count", 32'(error_count), 32'd1);
        checkOutput("single_bad_word_count", 32'(word_count), 32'd6);

        applyStimulus(16'h5555, 1'b1, 1'b1);
        applyStimulus(16'h5555, 1'b1, 1'b1);
        applyStimulus(16'h5555, 1'b1, 1'b1);
        applyStimulus(16'h5555, 1'b1, 1'b0);
        applyStimulus(16'h2021, 1'b0, 1'b1);
        applyStimulus(16'h2223, 1'b0, 1'b1);
        waitDrain("resync");
        checkOutput("resync_error_count", 32'(error_count), 32'd5);
        checkOutput("resync_word_count", 32'(word_count), 32'd12);

        // Error counter is 3 bits wide here: 5 -> 6 -> 7 -> 7 (saturated), err still pulses.
        applyStimulus(16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h2A2B, 1'b0, 1'b1);
        waitDrain("saturate");
        checkOutput("saturate_error_count", 32'(error_count), 32'd7);
        checkOutput("saturate_word_count", 32'(word_count), 32'd16);
        doReset();

        // FF00 is a legal lock word; next expected wraps to 0102.
        applyStimulus(16'hFF00, 1'b0, 1'b1);
        applyStimulus(16'h0102, 1'b0, 1'b1);
        applyStimulus(16'h0304, 1'b0, 1'b1);
        enReq = 1'b1;
        waitDrain("wrap");
        checkOutput("wrap_word_count", 32'(word_count), 32'd3);
        checkOutput("wrap_error_count", 32'(error_count), 32'd0);
        doReset();

        // 500 clean words with random empty/enable gaps.
        gapMode = 1'b1;
        pushCleanStream(8'h10, 500);
        enReq = 1'b1;
        waitDrain("gaps");
        gapMode = 1'b0;
        checkOutput("gaps_word_count", 32'(word_count), 32'd500);
        checkOutput("gaps_error_count", 32'(error_count), 32'd0);
        doReset();

        // Mid-stream reset: word 6 is in flight and word 7 is accepted on the reset edge; both are lost.
        pushCleanStream(8'h40, 20);
        enReq = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (word_count == 32'd5) hit = 1'b1;
        end
        if (!hit) checkOutput("midreset_wait_timeout", 32'd1, 32'd0);
        rst_n = 1'b0;
        enReq = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        checkOutput("midreset_locked", 32'(locked), 32'd0);
        checkOutput("midreset_err", 32'(err), 32'd0);
        checkOutput("midreset_word_count", 32'(word_count), 32'd0);
        checkOutput("midreset_error_count", 32'(error_count), 32'd0);
        enReq = 1'b1;
        waitDrain("midreset");
        checkOutput("midreset_final_word_count", 32'(word_count), 32'd13);
        checkOutput("midreset_final_error_count", 32'(error_count), 32'd0);
        checkOutput("midreset_final_locked", 32'(locked), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
